// File: rtl/simd_div_axil_slave_if.sv
// AXI4-Lite bus bundle for simd_div_axil_slave: write address/data/response
// and read address/data channels, with master and slave views.
interface simd_div_axil_slave_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/simd_div_axil_slave.sv
// AXI4-Lite slave wrapping a 4-lane 8-bit unsigned restoring divider.
// Optional macro SIMD_DIV_REM_EN builds the REMAINDER register at 0x10;
// without it 0x10 reads 0 and quotient behaviour is identical.
module simd_div_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  simd_div_axil_slave_if.slave  s_axi
);
  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [WORD_W-1:0] W_DIVIDEND  = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_DIVISOR   = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_CTRL      = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_QUOTIENT  = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_REMAINDER = WORD_W'(4);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  logic                          rst_q;
  logic                          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_mux;
  logic [3:0][7:0]               dividend, divisor, quotient;
  logic [3:0][7:0]               rem_w, quo_w, den_w, rem_nx, quo_nx;
  logic [3:0][8:0]               trial;
  logic [3:0]                    div0, zero_lane;
  logic                          done;
  logic [2:0]                    cnt;
  logic [31:0]                   rd_rem;
  logic [WORD_W-1:0]             wr_word, rd_word;
  logic                          wr_fire, rd_fire, start_ok, last_step;
  logic                          unused;

  assign wr_word   = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word   = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_fire   = awready_q & s_axi.awvalid & s_axi.wvalid;
  assign rd_fire   = arready_q & s_axi.arvalid;
  assign start_ok  = wr_fire & (wr_word == W_CTRL) & s_axi.wstrb[0] &
                     s_axi.wdata[0] & (state == IDLE);
  assign last_step = (state == RUN) & (cnt == 3'd0);
  assign unused    = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = awready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  // Reset release synchroniser; assertion propagates asynchronously.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rst_q <= 1'b0;
    else                rst_q <= 1'b1;
  end

  // Write channel: one-cycle AW/W ready pulse, then hold B until accepted.
  always_ff @(posedge S_AXI_ACLK or negedge rst_q) begin
    if (!rst_q) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      awready_q <= s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
      if (wr_fire)                          bvalid_q <= 1'b1;
      else if (bvalid_q && s_axi.bready)    bvalid_q <= 1'b0;
    end
  end

  // Read channel: one-cycle AR ready pulse, registered data held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge rst_q) begin
    if (!rst_q) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= s_axi.arvalid & ~rvalid_q & ~arready_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Read data selection from current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    case (rd_word)
      W_DIVIDEND:  rd_mux = dividend;
      W_DIVISOR:   rd_mux = divisor;
      W_CTRL:      rd_mux = {24'h0, div0, 1'b0, done, state == RUN, 1'b0};
      W_QUOTIENT:  rd_mux = quotient;
      W_REMAINDER: rd_mux = rd_rem;
      default:     rd_mux = '0;
    endcase
  end

  // One restoring step per lane: shift in next dividend bit, subtract if it fits.
  always_comb begin
    trial     = '0;
    rem_nx    = '0;
    quo_nx    = '0;
    zero_lane = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      trial[i]     = {rem_w[i], quo_w[i][7]};
      zero_lane[i] = (den_w[i] == 8'h00);
      if (trial[i] >= {1'b0, den_w[i]}) begin
        rem_nx[i] = 8'(trial[i] - {1'b0, den_w[i]});
        quo_nx[i] = {quo_w[i][6:0], 1'b1};
      end else begin
        rem_nx[i] = trial[i][7:0];
        quo_nx[i] = {quo_w[i][6:0], 1'b0};
      end
    end
  end

  // Divider FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge rst_q) begin
    if (!rst_q) state <= IDLE;
    else        state <= state_nx;
  end

  // Divider FSM next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok)        state_nx = RUN;
      RUN:     if (cnt == 3'd0)     state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // Register file writes and divider datapath.
  // A zero divisor needs no special case: every step subtracts 0, so the
  // quotient fills with ones and the partial remainder ends up as the dividend.
  always_ff @(posedge S_AXI_ACLK or negedge rst_q) begin
    if (!rst_q) begin
      dividend <= '0;
      divisor  <= '0;
      quotient <= '0;
      rem_w    <= '0;
      quo_w    <= '0;
      den_w    <= '0;
      div0     <= '0;
      done     <= 1'b0;
      cnt      <= '0;
    end else begin
      if (wr_fire) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (s_axi.wstrb[b]) begin
            if (wr_word == W_DIVIDEND) dividend[b] <= s_axi.wdata[8*b +: 8];
            if (wr_word == W_DIVISOR)  divisor[b]  <= s_axi.wdata[8*b +: 8];
          end
        end
      end
      if (start_ok) begin
        rem_w <= '0;
        quo_w <= dividend;
        den_w <= divisor;
        div0  <= '0;
        done  <= 1'b0;
        cnt   <= 3'd7;
      end else if (state == RUN) begin
        rem_w <= rem_nx;
        quo_w <= quo_nx;
        cnt   <= cnt - 3'd1;
        if (last_step) begin
          quotient <= quo_nx;
          div0     <= zero_lane;
          done     <= 1'b1;
        end
      end
    end
  end

`ifdef SIMD_DIV_REM_EN
  logic [3:0][7:0] remainder;

  // Remainder result register, updated together with the quotient.
  always_ff @(posedge S_AXI_ACLK or negedge rst_q) begin
    if (!rst_q)         remainder <= '0;
    else if (last_step) remainder <= rem_nx;
  end

  assign rd_rem = remainder;
`else
  assign rd_rem = '0;
`endif

endmodule
